// File: rtl/rx_anc_framer.sv
// rx_anc_framer: buffers rx_anc baseband IQ samples in a small FIFO and frames them
// into AXI-stream packets made of one {spp, seqnum} header and spp {I, Q} data words.
module rx_anc_framer #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_AW    = 5,
    parameter int SPP_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      srst,
    input  logic [DATA_WIDTH-1:0]     itx,
    input  logic [DATA_WIDTH-1:0]     qtx,
    input  logic                      in_tvalid,
    output logic                      in_tready,
    input  logic [SPP_WIDTH-1:0]      spp,
    output logic [2*DATA_WIDTH-1:0]   out_tdata,
    output logic                      out_tvalid,
    output logic                      out_tlast,
    input  logic                      out_tready,
    output logic [FIFO_AW:0]          fifo_level,
    output logic [31:0]               stall_cnt,
    output logic [DATA_WIDTH-1:0]     seqnum
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]        FULL_LEVEL = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0]        LVL_ZERO   = {(FIFO_AW+1){1'b0}};
    localparam logic [FIFO_AW:0]        LVL_ONE    = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [FIFO_AW-1:0]      PTR_ONE    = {{(FIFO_AW-1){1'b0}}, 1'b1};
    localparam logic [FIFO_AW-1:0]      PTR_ZERO   = {FIFO_AW{1'b0}};
    localparam logic [SPP_WIDTH-1:0]    SPP_ZERO   = {SPP_WIDTH{1'b0}};
    localparam logic [SPP_WIDTH-1:0]    SPP_ONE    = {{(SPP_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0]   SEQ_ZERO   = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0]   SEQ_ONE    = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*DATA_WIDTH-1:0] WORD_ZERO  = {(2*DATA_WIDTH){1'b0}};
    localparam logic [31:0]             STALL_MAX  = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    logic [2*DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [FIFO_AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]        count_q, count_d;
    logic                    in_rdy_q, in_rdy_d;
    logic [31:0]             stall_q, stall_d;
    logic [2*DATA_WIDTH-1:0] head_d;

    state_t                  state_q, state_d;
    logic [SPP_WIDTH-1:0]    spp_l_q, spp_l_d;
    logic [SPP_WIDTH-1:0]    dcnt_q, dcnt_d;
    logic [DATA_WIDTH-1:0]   seq_q, seq_d;
    logic                    tvalid_q, tvalid_d;
    logic                    tlast_q, tlast_d;
    logic [2*DATA_WIDTH-1:0] tdata_q, tdata_d;

    logic push_s, hs_s, pop_s;

    // Header length field: spp truncated or zero-extended to the sample width.
    function automatic logic [DATA_WIDTH-1:0] hdr_len(input logic [SPP_WIDTH-1:0] n);
        logic [SPP_WIDTH+DATA_WIDTH-1:0] wide;
        wide = {{DATA_WIDTH{1'b0}}, n};
        return wide[DATA_WIDTH-1:0];
    endfunction

    // Handshake qualifiers, all derived from registered state plus the strobes.
    always_comb begin
        push_s = in_tvalid & in_rdy_q;
        hs_s   = tvalid_q & out_tready;
        pop_s  = hs_s & (state_q == ST_DATA);
    end

    // FIFO pointers, occupancy, backpressure, stall statistics and next head word.
    always_comb begin
        if (push_s) wr_ptr_d = wr_ptr_q + PTR_ONE;
        else        wr_ptr_d = wr_ptr_q;
        if (pop_s)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        else        rd_ptr_d = rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + LVL_ONE;
            2'b01:   count_d = count_q - LVL_ONE;
            default: count_d = count_q;
        endcase
        in_rdy_d = (count_d != FULL_LEVEL);
        if (in_tvalid && !in_rdy_q && (stall_q != STALL_MAX)) stall_d = stall_q + 32'd1;
        else                                                   stall_d = stall_q;
        // A sample written this cycle into the slot that becomes the head bypasses the array.
        if (push_s && (wr_ptr_q == rd_ptr_d)) head_d = {itx, qtx};
        else                                  head_d = mem_q[rd_ptr_d];
    end

    // Framing FSM next state and the output word it will present next cycle.
    always_comb begin
        state_d = state_q;
        spp_l_d = spp_l_q;
        dcnt_d  = dcnt_q;
        seq_d   = seq_q;
        case (state_q)
            ST_IDLE: begin
                if (count_q != LVL_ZERO) begin
                    spp_l_d = (spp == SPP_ZERO) ? SPP_ONE : spp;
                    state_d = ST_HDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (hs_s) begin
                    dcnt_d  = SPP_ZERO;
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_DATA: begin
                if (hs_s) begin
                    dcnt_d = dcnt_q + SPP_ONE;
                    if (tlast_q) begin
                        seq_d   = seq_q + SEQ_ONE;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_HDR: begin
                tvalid_d = 1'b1;
                tlast_d  = 1'b0;
                tdata_d  = {hdr_len(spp_l_d), seq_d};
            end
            ST_DATA: begin
                tvalid_d = (count_d != LVL_ZERO);
                tlast_d  = (dcnt_d == (spp_l_d - SPP_ONE));
                tdata_d  = head_d;
            end
            default: begin
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
                tdata_d  = WORD_ZERO;
            end
        endcase
    end

    // Sample storage; contents need no reset because occupancy governs visibility.
    always_ff @(posedge clk) begin
        if (push_s && !srst) begin
            mem_q[wr_ptr_q] <= {itx, qtx};
        end
    end

    // State registers with async reset and synchronous clear taking priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            count_q  <= LVL_ZERO;
            in_rdy_q <= 1'b1;
            stall_q  <= 32'd0;
            state_q  <= ST_IDLE;
            spp_l_q  <= SPP_ONE;
            dcnt_q   <= SPP_ZERO;
            seq_q    <= SEQ_ZERO;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= WORD_ZERO;
        end else if (srst) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            count_q  <= LVL_ZERO;
            in_rdy_q <= 1'b1;
            stall_q  <= 32'd0;
            state_q  <= ST_IDLE;
            spp_l_q  <= SPP_ONE;
            dcnt_q   <= SPP_ZERO;
            seq_q    <= SEQ_ZERO;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= WORD_ZERO;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            in_rdy_q <= in_rdy_d;
            stall_q  <= stall_d;
            state_q  <= state_d;
            spp_l_q  <= spp_l_d;
            dcnt_q   <= dcnt_d;
            seq_q    <= seq_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tdata_q  <= tdata_d;
        end
    end

    assign in_tready  = in_rdy_q;
    assign out_tdata  = tdata_q;
    assign out_tvalid = tvalid_q;
    assign out_tlast  = tlast_q;
    assign fifo_level = count_q;
    assign stall_cnt  = stall_q;
    assign seqnum     = seq_q;

endmodule

// File: tb/tb_rx_anc_framer.sv
// Bench for rx_anc_framer: a queue-based packet model predicts every output word,
// level, ready, stall count and sequence number; directed cases pin exact values.
module tb_rx_anc_framer;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        srst = 1'b0;
    logic [15:0] itx = 16'd0;
    logic [15:0] qtx = 16'd0;
    logic        in_tvalid = 1'b0;
    logic        in_tready;
    logic [15:0] spp = 16'd4;
    logic [31:0] out_tdata;
    logic        out_tvalid;
    logic        out_tlast;
    logic        out_tready = 1'b0;
    logic [5:0]  fifo_level;
    logic [31:0] stall_cnt;
    logic [15:0] seqnum;

    rx_anc_framer #(.DATA_WIDTH(16), .FIFO_AW(5), .SPP_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .srst(srst), .itx(itx), .qtx(qtx),
        .in_tvalid(in_tvalid), .in_tready(in_tready), .spp(spp),
        .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tlast(out_tlast),
        .out_tready(out_tready), .fifo_level(fifo_level), .stall_cnt(stall_cnt),
        .seqnum(seqnum)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state (value after the most recent clock edge).
    logic [31:0] mq[$];
    logic [15:0] seq_m = 16'd0;
    logic [31:0] stall_m = 32'd0;
    bit          in_pkt = 1'b0;
    int          pkt_len = 0;
    int          pkt_idx = 0;
    int          hdr_spp_exp = 4;
    bit          pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [31:0] pd = 32'd0;
    logic [31:0] log_w[$];
    bit          log_l[$];
    int          log_c[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        seq_m = 16'd0;
        stall_m = 32'd0;
        in_pkt = 1'b0;
        pkt_idx = 0;
        pv = 1'b0;
    endtask

    // Compare process: checks outputs against the model, then advances the model.
    int          lvl0;
    int          eff;
    logic [31:0] exp_w;
    bit          exp_l;
    bit          have_exp;
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            model_clear();
            chk("rst_tvalid", out_tvalid, 1'b0);
            chk("rst_tlast", out_tlast, 1'b0);
            chk("rst_tdata", out_tdata, 32'd0);
            chk("rst_level", fifo_level, 6'd0);
            chk("rst_tready", in_tready, 1'b1);
            chk("rst_stall", stall_cnt, 32'd0);
            chk("rst_seq", seqnum, 16'd0);
        end else begin
            lvl0 = mq.size();
            chk("level", fifo_level, lvl0);
            chk("in_tready", in_tready, lvl0 != DEPTH);
            chk("stall_cnt", stall_cnt, stall_m);
            chk("seqnum", seqnum, seq_m);
            if (pv && !pr) begin
                chk("hold_valid", out_tvalid, 1'b1);
                chk("hold_data", out_tdata, pd);
                chk("hold_last", out_tlast, pl);
            end
            if (srst) begin
                model_clear();
            end else begin
                if (out_tvalid && out_tready) begin
                    have_exp = 1'b1;
                    exp_l = 1'b0;
                    if (!in_pkt) begin
                        eff = (hdr_spp_exp == 0) ? 1 : hdr_spp_exp;
                        exp_w = {eff[15:0], seq_m};
                        in_pkt = 1'b1;
                        pkt_len = eff;
                        pkt_idx = 0;
                    end else if (mq.size() == 0) begin
                        have_exp = 1'b0;
                        chk("underflow", 1'b1, 1'b0);
                    end else begin
                        exp_w = mq.pop_front();
                        exp_l = (pkt_idx == pkt_len - 1);
                        pkt_idx++;
                        if (exp_l) begin
                            in_pkt = 1'b0;
                            seq_m = seq_m + 16'd1;
                        end
                    end
                    if (have_exp) begin
                        chk("out_tdata", out_tdata, exp_w);
                        chk("out_tlast", out_tlast, exp_l);
                    end
                    log_w.push_back(out_tdata);
                    log_l.push_back(out_tlast);
                    log_c.push_back(cyc);
                end
                if (in_tvalid) begin
                    if (lvl0 != DEPTH) mq.push_back({itx, qtx});
                    else if (stall_m != 32'hFFFF_FFFF) stall_m = stall_m + 32'd1;
                end
                pv = out_tvalid;
                pr = out_tready;
                pd = out_tdata;
                pl = out_tlast;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_w.delete();
        log_l.delete();
        log_c.delete();
    endtask

    task automatic wait_log(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (log_w.size() >= n) break;
            tick();
        end
        chk("wait_log", log_w.size() >= n, 1'b1);
    endtask

    task automatic push_seq(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            in_tvalid = 1'b1;
            itx = 16'(base + i);
            qtx = 16'(-(base + i));
            tick();
        end
        in_tvalid = 1'b0;
    endtask

    task automatic send(input int n, input int pvp, input int prp);
        int acc = 0;
        for (int b = 0; b < 20000 && acc < n; b++) begin
            in_tvalid = ($urandom_range(99) < pvp);
            itx = 16'($urandom);
            qtx = 16'($urandom);
            out_tready = ($urandom_range(99) < prp);
            @(negedge clk);
            if (in_tvalid && in_tready) acc++;
            @(posedge clk);
            #1;
        end
        in_tvalid = 1'b0;
        chk("send_budget", acc, n);
    endtask

    task automatic drain(input int prp);
        in_tvalid = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (mq.size() == 0 && !in_pkt) break;
            out_tready = ($urandom_range(99) < prp);
            tick();
        end
        chk("drain", (mq.size() == 0) && !in_pkt, 1'b1);
        repeat (2) tick();
    endtask

    int push_c;
    int sv;
    int n;
    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        tick();
        chk("init_tvalid", out_tvalid, 1'b0);
        chk("init_level", fifo_level, 6'd0);
        chk("init_tready", in_tready, 1'b1);
        chk("init_seq", seqnum, 16'd0);
        chk("init_stall", stall_cnt, 32'd0);

        // Single packet, spp=4.
        spp = 16'd4; hdr_spp_exp = 4; out_tready = 1'b1; clear_log();
        push_c = cyc;
        push_seq(4, 1);
        wait_log(5, 50);
        chk("p1_hdr", log_w[0], 32'h0004_0000);
        chk("p1_d1", log_w[1], 32'h0001_FFFF);
        chk("p1_d2", log_w[2], 32'h0002_FFFE);
        chk("p1_d3", log_w[3], 32'h0003_FFFD);
        chk("p1_d4", log_w[4], 32'h0004_FFFC);
        for (int i = 0; i < 5; i++) begin
            chk("p1_last", log_l[i], i == 4);
            chk("p1_cycle", log_c[i], push_c + 2 + i);
        end
        tick();
        chk("p1_seq", seqnum, 16'd1);

        // Backpressure into a full FIFO, then drain with random stalls.
        spp = 16'd32; hdr_spp_exp = 32; out_tready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            in_tvalid = 1'b1; itx = 16'(100 + i); qtx = 16'($urandom);
            tick();
        end
        in_tvalid = 1'b0;
        chk("full_level", fifo_level, 6'd32);
        chk("full_stall", stall_cnt, 32'd8);
        chk("full_tready", in_tready, 1'b0);
        drain(60);
        chk("full_seq", seqnum, 16'd2);

        // spp change mid-packet takes effect at the next header.
        spp = 16'd3; hdr_spp_exp = 3; out_tready = 1'b1; clear_log();
        fork
            push_seq(8, 16'h10);
            begin
                wait_log(2, 50);
                spp = 16'd5; hdr_spp_exp = 5;
            end
        join
        wait_log(10, 100);
        chk("chg_hdr0", log_w[0], 32'h0003_0002);
        chk("chg_hdr1", log_w[4], 32'h0005_0003);
        chk("chg_last3", log_l[3], 1'b1);
        chk("chg_last8", log_l[9], 1'b1);
        chk("chg_nolast2", log_l[2], 1'b0);
        chk("chg_nolast7", log_l[8], 1'b0);
        tick();
        chk("chg_seq", seqnum, 16'd4);

        // spp=0 behaves as one sample per packet.
        spp = 16'd0; hdr_spp_exp = 0; clear_log();
        in_tvalid = 1'b1; itx = 16'h00AA; qtx = 16'h0055; tick(); in_tvalid = 1'b0;
        wait_log(2, 50);
        chk("spp0_hdr", log_w[0], 32'h0001_0004);
        chk("spp0_data", log_w[1], 32'h00AA_0055);
        chk("spp0_last", log_l[1], 1'b1);
        tick();
        chk("spp0_seq", seqnum, 16'd5);

        // Synchronous clear mid-packet.
        spp = 16'd8; hdr_spp_exp = 8; clear_log(); out_tready = 1'b1;
        fork
            push_seq(8, 16'h40);
            begin
                wait_log(4, 50);
                out_tready = 1'b0;
            end
        join
        srst = 1'b1; tick(); srst = 1'b0;
        chk("srst_level", fifo_level, 6'd0);
        chk("srst_tvalid", out_tvalid, 1'b0);
        chk("srst_seq", seqnum, 16'd0);
        chk("srst_tready", in_tready, 1'b1);
        chk("srst_words", log_w.size(), 4);
        tick();
        chk("srst_idle", out_tvalid, 1'b0);
        clear_log(); out_tready = 1'b1;
        push_seq(8, 16'h80);
        wait_log(9, 60);
        chk("srst_hdr", log_w[0], 32'h0008_0000);
        chk("srst_last", log_l[8], 1'b1);
        drain(100);

        // Randomized segments, spp constant within each.
        for (int s = 0; s < 12; s++) begin
            sv = $urandom_range(0, 6);
            spp = 16'(sv); hdr_spp_exp = sv;
            n = ((sv == 0) ? 1 : sv) * $urandom_range(1, 6);
            send(n, $urandom_range(30, 100), $urandom_range(20, 100));
            drain(70);
        end

        // Asynchronous reset mid-stream.
        out_tready = 1'b0;
        push_seq(5, 16'h200);
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        #1;
        chk("arst_tvalid", out_tvalid, 1'b0);
        chk("arst_level", fifo_level, 6'd0);
        chk("arst_seq", seqnum, 16'd0);
        chk("arst_stall", stall_cnt, 32'd0);
        chk("arst_tready", in_tready, 1'b1);
        @(posedge clk);
        #1 reset = 1'b1;
        spp = 16'd2; hdr_spp_exp = 2; out_tready = 1'b1; clear_log();
        push_seq(2, 16'h300);
        wait_log(3, 50);
        chk("arst_hdr", log_w[0], 32'h0002_0000);
        drain(100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_anc_framer.md
Name: rx_anc_framer

Overview:
- Sits directly downstream of rx_anc and consumes its baseband IQ output (itx/qtx).
- Buffers samples in a small FIFO and frames them into AXI-stream packets for the host/radio output path.
- Each packet is one header word {spp, seqnum} followed by exactly spp IQ data words; tlast is asserted on the last data word.
- Provides in_tready backpressure to rx_anc and exposes FIFO level and stall statistics.

Parameters:
DATA_WIDTH, 16, width of each I and Q sample; out_tdata is 2*DATA_WIDTH.
FIFO_AW, 5, FIFO address width; depth = 2^FIFO_AW samples.
SPP_WIDTH, 16, width of the spp (samples per packet) input.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
srst  in  1  synchronous clear, active-high
itx  in  DATA_WIDTH  I sample from rx_anc
qtx  in  DATA_WIDTH  Q sample from rx_anc
in_tvalid  in  1  input sample valid
in_tready  out  1  input ready (FIFO not full)
spp  in  SPP_WIDTH  samples per packet; latched at packet start
out_tdata  out  2*DATA_WIDTH  header or data word; data = {itx, qtx}
out_tvalid  out  1  output valid
out_tlast  out  1  last data word of packet
out_tready  in  1  downstream ready
fifo_level  out  FIFO_AW+1  current FIFO occupancy
stall_cnt  out  32  saturating count of cycles with in_tvalid=1 and in_tready=0
seqnum  out  DATA_WIDTH  sequence number of the next/current packet

Behaviour:
- Reset (reset=0, async) and srst=1 (sync) both clear state as follows:
  - FIFO emptied; state IDLE; seqnum=0; stall_cnt=0.
  - out_tvalid=0, out_tlast=0, out_tdata=0, in_tready=1, fifo_level=0.
- srst has priority over all other activity. srst during a packet abandons it with no tlast; the next packet starts with a fresh header and seqnum=0.
- Input: in_tready = (fifo_level != 2^FIFO_AW), computed from the registered count.
  - A push occurs when in_tvalid & in_tready.
  - When full, no push is accepted even if a pop occurs in the same cycle.
  - Push and pop in the same cycle leave fifo_level unchanged.
- stall_cnt increments on each cycle with in_tvalid & !in_tready and saturates at 2^32-1.
- No combinational path from out_tready to out_tvalid, out_tdata, or in_tready.
- FSM states:
  - IDLE: out_tvalid=0. If fifo_level != 0, latch spp_l = (spp==0 ? 1 : spp) and go to HDR next cycle.
  - HDR: out_tvalid=1, out_tlast=0, out_tdata = {spp_l truncated/zero-extended to DATA_WIDTH, seqnum}. Hold until out_tready; on handshake, data count=0 and go to DATA.
  - DATA: out_tvalid = (fifo_level != 0); out_tdata = FIFO head {I, Q}; out_tlast = (count == spp_l-1).
    - On handshake: pop, count++.
    - If tlast on that handshake: seqnum++ (wraps at 2^DATA_WIDTH) and go to IDLE.
- Valid and data stability: while out_tvalid=1 and out_tready=0, out_tdata and out_tlast hold stable. out_tvalid never drops without a handshake, except on srst/reset.
- spp changes mid-packet have no effect until the next IDLE->HDR transition.
- Latency:
  - Sample accepted at edge k gives fifo_level=1 after edge k.
  - State HDR is reached after edge k+1, so the header is valid in cycle k+2.
  - With out_tready held high, the first data word is valid the cycle after the header handshake.
  - Steady-state throughput is 1 word/cycle within a packet; there is one idle cycle (IDLE) between packets.
- FIFO order is strictly first-in first-out. Pointer wrap at 2^FIFO_AW is transparent.

Test Plan:
- Reset: reset=0 mid-stream → next cycle out_tvalid=0, fifo_level=0, seqnum=0, stall_cnt=0, in_tready=1.
- Single packet: spp=4, out_tready=1, push I/Q = (1,-1),(2,-2),(3,-3),(4,-4) → header 0x0004_0000 first, then 0x0001_FFFF, 0x0002_FFFE, 0x0003_FFFD, 0x0004_FFFC; tlast only on the last word; seqnum=1 afterwards.
- Backpressure and full: FIFO_AW=5, out_tready=0, in_tvalid=1 for 40 cycles → in_tready falls after 32 accepts, fifo_level=32, stall_cnt=8. Then out_tready=1 → header plus all 32 samples emerge in order, each held stable during stalls.
- Packet boundaries and spp change: spp=3, then spp changed to 5 mid-packet; stream 8 samples → packet 0 has header spp=3 and 3 data words, packet 1 has header {5, 1}. tlast on data words 3 and 8.
- spp=0 edge: spp=0 with one sample → header 0x0001_0000, then one data word with tlast.
- srst mid-packet: spp=8, 3 words sent, then srst pulse → FIFO cleared and out_tvalid=0. The next sample produces a header with seqnum=0.
